// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - decode-at-enqueue instruction FIFO between IF and EX
module decode_queue #(
  parameter int WORD  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WORD-1:0]  in_inst,
  input  logic [WORD-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WORD-1:0]  out_inst,
  output logic [WORD-1:0]  out_pc,
  output logic [2:0]       out_reg_wb,
  output logic [1:0]       out_mem,
  output logic             out_branch,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  // Result-select encodings shared with the EX stage
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_CMP = 2'b10;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Per-entry storage; ctl packs {reg_write, res_sel[1:0], mem_read, mem_write, branch}
  logic [WORD-1:0] inst_q [DEPTH];
  logic [WORD-1:0] pc_q   [DEPTH];
  logic [5:0]      ctl_q  [DEPTH];

  logic       push;
  logic       pop;
  logic       full;
  logic       dec_reg_write;
  logic [1:0] dec_res_sel;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_branch;
  logic [5:0] dec_ctl;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign in_ready  = !rst && !flush && !full;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  // A pop in a flush or reset cycle is swallowed by the clear
  assign pop       = out_valid && out_ready && !flush && !rst;

  // Decode control fields from the incoming instruction word
  always_comb begin
    dec_reg_write = (in_inst[31:26] == 6'b010011) ||
                    (in_inst[31:26] == 6'b010101) ||
                    !in_inst[30];
    if (in_inst[30])
      dec_res_sel = RES_CMP;
    else if (in_inst[29])
      dec_res_sel = RES_MEM;
    else
      dec_res_sel = RES_ALU;
    dec_mem_read  = (in_inst[31:24] == 8'b00101000);
    dec_mem_write = (in_inst[31:24] == 8'b00101001);
    dec_branch    = (in_inst[31:30] == 2'b01);
    dec_ctl       = {dec_reg_write, dec_res_sel, dec_mem_read, dec_mem_write, dec_branch};
  end

  // Next-state for pointers and occupancy; flush empties the queue
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)
        count_d = count_q + CNT_W'(1);
      else if (pop && !push)
        count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write; entry 0 is cleared on reset so the head reads zero afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q[0] <= '0;
      pc_q[0]   <= '0;
      ctl_q[0]  <= '0;
    end else if (push) begin
      inst_q[wr_ptr_q] <= in_inst;
      pc_q[wr_ptr_q]   <= in_pc;
      ctl_q[wr_ptr_q]  <= dec_ctl;
    end
  end

  assign out_inst   = inst_q[rd_ptr_q];
  assign out_pc     = pc_q[rd_ptr_q];
  assign out_reg_wb = ctl_q[rd_ptr_q][5:3];
  assign out_mem    = ctl_q[rd_ptr_q][2:1];
  assign out_branch = ctl_q[rd_ptr_q][0];
  assign count      = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - model-checked directed bench for decode_queue
module tb_decode_queue;

  localparam int WORD  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WORD-1:0]  in_inst = '0;
  logic [WORD-1:0]  in_pc = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WORD-1:0]  out_inst;
  logic [WORD-1:0]  out_pc;
  logic [2:0]       out_reg_wb;
  logic [1:0]       out_mem;
  logic             out_branch;
  logic [CNT_W-1:0] count;

  int n_chk = 0;
  int n_fail = 0;

  decode_queue #(.WORD(WORD), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_reg_wb(out_reg_wb), .out_mem(out_mem), .out_branch(out_branch), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of {inst, pc} plus decode computed from the field rules
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];
  bit   started = 0;
  bit   after_rst = 0;

  function automatic logic [5:0] model_ctl(input logic [31:0] inst);
    logic       rw;
    logic [1:0] rs;
    rw = (inst[31:26] == 6'b010011) || (inst[31:26] == 6'b010101) || (inst[30] == 1'b0);
    if (inst[30] == 1'b1)         rs = 2'b10;
    else if (inst[30:29] == 2'b01) rs = 2'b01;
    else                           rs = 2'b00;
    return {rw, rs, inst[31:24] == 8'h28, inst[31:24] == 8'h29, inst[31:30] == 2'b01};
  endfunction

  always @(posedge clk) begin
    bit m_ready;
    bit m_pop;
    m_ready = !rst && !flush && (mq.size() < DEPTH);
    m_pop   = (mq.size() > 0) && out_ready && !rst && !flush;
    if (rst || flush) begin
      mq.delete();
      if (rst) begin
        after_rst = 1;
        started = 1;
      end
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (in_valid && m_ready) begin
        mq.push_back('{in_inst, in_pc});
        after_rst = 0;
      end
    end
  end

  // Cycle-by-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (started) begin
      logic [5:0] c;
      check("m_count", 64'(count), 64'(mq.size()));
      check("m_out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("m_in_ready", 64'(in_ready), 64'(!rst && !flush && mq.size() < DEPTH));
      if (mq.size() != 0) begin
        c = model_ctl(mq[0].inst);
        check("m_out_inst", 64'(out_inst), 64'(mq[0].inst));
        check("m_out_pc", 64'(out_pc), 64'(mq[0].pc));
        check("m_out_reg_wb", 64'(out_reg_wb), 64'(c[5:3]));
        check("m_out_mem", 64'(out_mem), 64'(c[2:1]));
        check("m_out_branch", 64'(out_branch), 64'(c[0]));
      end else if (after_rst) begin
        check("m_rst_data", {out_inst, out_pc}, 64'h0);
        check("m_rst_ctl", 64'({out_reg_wb, out_mem, out_branch}), 64'h0);
      end
    end
  end

  task automatic push_one(input logic [31:0] inst, input logic [31:0] pc);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL push_timeout: in_ready stayed 0 for pc %0h", pc);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_cycles(input int n);
    out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    bit acc;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit accepted;
    // Reset and decode
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    @(posedge clk); #1;
    push_one(32'h4C000020, 32'h1C000000);
    @(negedge clk);
    check("jirl_valid", 64'(out_valid), 64'd1);
    check("jirl_pc", 64'(out_pc), 64'h1C000000);
    check("jirl_reg_wb", 64'(out_reg_wb), 64'b110);
    check("jirl_branch", 64'(out_branch), 64'd1);
    check("jirl_mem", 64'(out_mem), 64'd0);
    @(posedge clk); #1;
    pop_cycles(1);

    // Load/store decode
    push_one(32'h28800000, 32'h10);
    push_one(32'h29800000, 32'h14);
    @(negedge clk);
    check("ld_mem", 64'(out_mem), 64'b10);
    check("ld_reg_wb", 64'(out_reg_wb), 64'b101);
    @(posedge clk); #1;
    pop_cycles(1);
    @(negedge clk);
    check("st_mem", 64'(out_mem), 64'b01);
    check("st_reg_wb", 64'(out_reg_wb), 64'b101);
    @(posedge clk); #1;
    pop_cycles(1);

    // Fill and wrap: pointers start at 3 here, so the fill wraps past the top entry
    for (int i = 0; i < 4; i++) push_one(32'h00100000 + i, 32'(4 * i));
    @(negedge clk);
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_head_pc", 64'(out_pc), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_inst  = 32'h00100010;
    in_pc    = 32'd16;
    repeat (3) begin
      @(negedge clk);
      check("held_in_ready", 64'(in_ready), 64'd0);
      check("held_count", 64'(count), 64'd4);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("drain_valid", 64'(out_valid), 64'd1);
      check("drain_pc", 64'(out_pc), 64'(4 * k));
      accepted = in_valid && in_ready;
      @(posedge clk); #1;
      if (accepted) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    @(negedge clk);
    check("drain_count", 64'(count), 64'd0);
    check("drain_src_taken", 64'(in_valid), 64'd0);
    @(posedge clk); #1;

    // Simultaneous push and pop at count 2
    push_one(32'h02000000, 32'h100);
    push_one(32'h02000001, 32'h104);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_inst = 32'h02000002 + k;
      in_pc   = 32'h108 + 4 * k;
      @(negedge clk);
      check("sim_count", 64'(count), 64'd2);
      check("sim_pc", 64'(out_pc), 64'(32'h100 + 4 * k));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    pop_cycles(2);
    @(negedge clk);
    check("sim_empty", 64'(count), 64'd0);
    @(posedge clk); #1;

    // Flush with a push and a pop in the same cycle
    push_one(32'h54000000, 32'h200);
    push_one(32'h54000001, 32'h204);
    push_one(32'h54000002, 32'h208);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_inst   = 32'h540000FF;
    in_pc     = 32'h2FC;
    out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    push_one(32'h00300000, 32'h300);
    @(negedge clk);
    check("pf_valid", 64'(out_valid), 64'd1);
    check("pf_pc", 64'(out_pc), 64'h300);
    @(posedge clk); #1;

    // Reset mid-stream together with flush and a push
    push_one(32'h00300001, 32'h304);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
    in_inst = 32'h4C0000AA; in_pc = 32'h3FC;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("mr_count", 64'(count), 64'd0);
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_data", {out_inst, out_pc}, 64'h0);
    check("mr_ctl", 64'({out_reg_wb, out_mem, out_branch}), 64'h0);
    repeat (3) begin
      @(negedge clk);
      check("mr_stay_empty", 64'(out_valid), 64'd0);
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
